// File: rtl/axi3_rd_arbiter.sv
// Shares one AXI3 read channel among N_REQ masters, one burst in flight; grant held from AR to RLAST.
// Latency: 1 cycle to arbitrate, then AR and R pass through combinationally. Backpressure: m_arready/s_rready route only to the owner.
// Optional AXI3_RD_ARB_FIXED_PRIO_EN: lowest index always wins instead of round-robin.
module axi3_rd_arbiter #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              s_arvalid,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   s_araddr,
    input  logic [N_REQ*4-1:0]            s_arlen,
    input  logic [N_REQ*3-1:0]            s_arsize,
    input  logic [N_REQ*2-1:0]            s_arburst,
    input  logic [N_REQ*ID_WIDTH-1:0]     s_arid,
    output logic [N_REQ-1:0]              s_arready,
    output logic [N_REQ-1:0]              s_rvalid,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic [ID_WIDTH-1:0]           s_rid,
    input  logic [N_REQ-1:0]              s_rready,
    output logic                          m_arvalid,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [3:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic [ID_WIDTH-1:0]           m_arid,
    input  logic                          m_arready,
    input  logic                          m_rvalid,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic [ID_WIDTH-1:0]           m_rid,
    output logic                          m_rready,
    output logic [$clog2(N_REQ)-1:0]      grant,
    output logic                          busy,
    output logic                          err_burst
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [GW-1:0] winner;

`ifdef AXI3_RD_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (s_arvalid[k]) winner = GW'(k);
        end
    end
`else
    logic [GW-1:0] rr;

    // Scan from farthest to nearest offset so the first requester at or after rr wins.
    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (s_arvalid[(int'(rr) + k) % N_REQ]) winner = GW'((int'(rr) + k) % N_REQ);
        end
    end
`endif

    always_comb begin
        m_arvalid = 1'b0;
        m_araddr  = s_araddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
        m_arlen   = s_arlen[grant*4 +: 4];
        m_arsize  = s_arsize[grant*3 +: 3];
        m_arburst = s_arburst[grant*2 +: 2];
        m_arid    = s_arid[grant*ID_WIDTH +: ID_WIDTH];
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        case (state)
            ARB_ADDR: begin
                m_arvalid        = s_arvalid[grant];
                s_arready[grant] = m_arready;
            end
            ARB_DATA: begin
                s_rvalid[grant] = m_rvalid;
                m_rready        = s_rready[grant];
            end
            default: ;
        endcase
    end

    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;
    assign s_rid   = m_rid;
    assign busy    = (state != ARB_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            cnt       <= '0;
            err_burst <= 1'b0;
`ifndef AXI3_RD_ARB_FIXED_PRIO_EN
            rr        <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|s_arvalid) begin
                        grant <= winner;
                        state <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    // A requester withdrawing its AR forfeits the grant without moving rr.
                    if (!s_arvalid[grant]) begin
                        state <= ARB_IDLE;
                    end else if (m_arready) begin
                        cnt   <= s_arlen[grant*4 +: 4];
                        state <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (m_rvalid && m_rready) begin
                        if (cnt != 4'd0) cnt <= cnt - 4'd1;
                        if ((m_rlast && cnt != 4'd0) || (!m_rlast && cnt == 4'd0))
                            err_burst <= 1'b1;
                        if (m_rlast) begin
                            state <= ARB_IDLE;
`ifndef AXI3_RD_ARB_FIXED_PRIO_EN
                            rr    <= (int'(grant) == N_REQ - 1) ? '0 : grant + GW'(1);
`endif
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Scoreboard bench for axi3_rd_arbiter: directed requests push expected AR/R items, a negedge monitor pops and compares.
module tb_axi3_rd_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_arvalid = '0;
    logic [N*32-1:0] s_araddr = '0;
    logic [N*4-1:0]  s_arlen = '0;
    logic [N*3-1:0]  s_arsize = '0;
    logic [N*2-1:0]  s_arburst = '0;
    logic [N*4-1:0]  s_arid = '0;
    logic [N-1:0]    s_arready;
    logic [N-1:0]    s_rvalid;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [3:0]      s_rid;
    logic [N-1:0]    s_rready = '1;
    logic            m_arvalid;
    logic [31:0]     m_araddr;
    logic [3:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic [3:0]      m_arid;
    logic            m_arready = 1'b1;
    logic            m_rvalid = 1'b0;
    logic [31:0]     m_rdata = '0;
    logic [1:0]      m_rresp = '0;
    logic            m_rlast = 1'b0;
    logic [3:0]      m_rid = '0;
    logic            m_rready;
    logic [1:0]      grant;
    logic            busy;
    logic            err_burst;

    axi3_rd_arbiter #(.N_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arid(s_arid), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rready(s_rready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arid(m_arid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rid(m_rid), .m_rready(m_rready),
        .grant(grant), .busy(busy), .err_burst(err_burst)
    );

    always #5 clk = ~clk;

    typedef struct { int port; logic [31:0] addr; logic [3:0] len; } ar_t;
    typedef struct { int port; logic [31:0] data; logic last; logic [1:0] resp; } r_t;
    typedef struct { logic [31:0] data; logic last; logic [1:0] resp; logic [3:0] id; } beat_t;

    ar_t   pend_q[$];
    ar_t   exp_ar[$];
    r_t    exp_r[$];
    beat_t slave_q[$];

    int errors = 0;
    int checks = 0;
    int hs_cnt[N];
    int ar_stall = 0;
    logic ar_block = 1'b0;
    logic rtoggle = 1'b0;
    int short_n = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes an AR or R handshake.
    ar_t ea;
    r_t  er;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL ar_unexpected: handshake addr 0x%0h with no expected AR", m_araddr);
                end else begin
                    ea = exp_ar.pop_front();
                    chk("ar_grant", 64'(grant), 64'(ea.port));
                    chk("ar_addr", 64'(m_araddr), 64'(ea.addr));
                    chk("ar_len", 64'(m_arlen), 64'(ea.len));
                    chk("ar_id", 64'(m_arid), 64'(ea.port));
                    chk("ar_size_burst", {59'd0, m_arsize, m_arburst}, 64'h9);
                end
            end
            if (s_rvalid != '0) chk("rvalid_onehot", 64'($countones(s_rvalid)), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (s_rvalid[i] && s_rready[i]) begin
                    if (exp_r.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL r_unexpected: beat on port %0d data 0x%0h with none expected", i, s_rdata);
                    end else begin
                        er = exp_r.pop_front();
                        chk("r_port", 64'(i), 64'(er.port));
                        chk("r_data", 64'(s_rdata), 64'(er.data));
                        chk("r_last", 64'(s_rlast), 64'(er.last));
                        chk("r_resp", 64'(s_rresp), 64'(er.resp));
                        chk("r_id", 64'(s_rid), 64'(er.port));
                    end
                end
            end
        end
    end

    // One clock of requester + slave modelling; all drives land #1 after the rising edge.
    task automatic step();
        logic [N-1:0] rhs, arhs;
        logic mhs, mar;
        logic [31:0] ca;
        logic [3:0] cl, cid;
        int nb, k;
        beat_t b;
        ar_t p;
        @(negedge clk);
        rhs = s_rvalid & s_rready;
        arhs = s_arvalid & s_arready;
        mhs = m_rvalid & m_rready;
        mar = m_arvalid & m_arready;
        ca = m_araddr; cl = m_arlen; cid = m_arid;
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < N; i++) if (rhs[i]) hs_cnt[i]++;
            s_arvalid = s_arvalid & ~arhs;
            if (mhs && slave_q.size() > 0) void'(slave_q.pop_front());
            if (mar) begin
                nb = (short_n != 0) ? short_n : int'(cl) + 1;
                for (int j = 0; j < nb; j++) begin
                    b.data = ca + 32'(j);
                    b.last = (j == nb - 1);
                    b.resp = 2'(j);
                    b.id = cid;
                    slave_q.push_back(b);
                end
            end
        end
        k = 0;
        while (k < pend_q.size()) begin
            p = pend_q[k];
            if (!s_arvalid[p.port]) begin
                s_araddr[p.port*32 +: 32] = p.addr;
                s_arlen[p.port*4 +: 4] = p.len;
                s_arvalid[p.port] = 1'b1;
                pend_q.delete(k);
            end else begin
                k++;
            end
        end
        if (slave_q.size() > 0) begin
            m_rvalid = 1'b1;
            m_rdata = slave_q[0].data;
            m_rlast = slave_q[0].last;
            m_rresp = slave_q[0].resp;
            m_rid = slave_q[0].id;
        end else begin
            m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0; m_rresp = '0; m_rid = '0;
        end
        m_arready = !ar_block && (ar_stall == 0);
        if (ar_stall > 0) ar_stall--;
        s_rready = rtoggle ? ~s_rready : '1;
    endtask

    task automatic req(int p, logic [31:0] a, logic [3:0] len);
        ar_t r;
        r.port = p; r.addr = a; r.len = len;
        pend_q.push_back(r);
    endtask

    task automatic expect_burst(int p, logic [31:0] a, logic [3:0] len, int nb);
        ar_t x;
        r_t y;
        x.port = p; x.addr = a; x.len = len;
        exp_ar.push_back(x);
        for (int j = 0; j < nb; j++) begin
            y.port = p; y.data = a + 32'(j); y.last = (j == nb - 1); y.resp = 2'(j);
            exp_r.push_back(y);
        end
    endtask

    task automatic req_exp(int p, logic [31:0] a, logic [3:0] len, int nb);
        req(p, a, len);
        expect_burst(p, a, len, nb);
    endtask

    task automatic wait_idle(string tag, int budget);
        int n = 0;
        while ((busy || pend_q.size() != 0 || s_arvalid != '0 || slave_q.size() != 0 ||
                exp_r.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            errors++; checks++;
            $display("FAIL %s_timeout: still busy after %0d cycles (need idle)", tag, budget);
        end
        chk({tag, "_ar_drained"}, 64'(exp_ar.size()), 64'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        pend_q.delete(); slave_q.delete(); exp_ar.delete(); exp_r.delete();
        s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        for (int p = 0; p < N; p++) begin
            s_arid[p*4 +: 4] = 4'(p);
            s_arsize[p*3 +: 3] = 3'd2;
            s_arburst[p*2 +: 2] = 2'b01;
            hs_cnt[p] = 0;
        end

        // Reset state
        apply_reset();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_err", 64'(err_burst), 64'd0);
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_m_rready", 64'(m_rready), 64'd0);
        chk("rst_s_arready", 64'(s_arready), 64'd0);
        chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);

        // Single request, port 1, 8 beats
        req_exp(1, 32'h1FC0_0020, 4'd7, 8);
        step();
        chk("t1_idle_latency", 64'(m_arvalid), 64'd0);
        step();
        chk("t1_m_arvalid", 64'(m_arvalid), 64'd1);
        chk("t1_m_araddr", 64'(m_araddr), 64'h1FC0_0020);
        chk("t1_grant", 64'(grant), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_idle("t1", 60);
        chk("t1_beats_p1", 64'(hs_cnt[1]), 64'd8);
        chk("t1_beats_p0", 64'(hs_cnt[0]), 64'd0);
        chk("t1_beats_p2", 64'(hs_cnt[2]), 64'd0);
        chk("t1_err", 64'(err_burst), 64'd0);

        // Withdrawn AR on port 2
        ar_block = 1'b1;
        m_arready = 1'b0;
        req(2, 32'h0000_2200, 4'd0);
        step();
        step();
        chk("wd_grant", 64'(grant), 64'd2);
        chk("wd_busy", 64'(busy), 64'd1);
        chk("wd_m_arvalid", 64'(m_arvalid), 64'd1);
        s_arvalid[2] = 1'b0;
        step();
        chk("wd_back_idle", 64'(busy), 64'd0);
        chk("wd_no_arvalid", 64'(m_arvalid), 64'd0);
        ar_block = 1'b0;
        step();
        // rr still points at port 2, so port 2 beats port 0 under round-robin
`ifdef AXI3_RD_ARB_FIXED_PRIO_EN
        expect_burst(0, 32'h0000_0A00, 4'd0, 1);
        expect_burst(2, 32'h0000_2A00, 4'd0, 1);
`else
        expect_burst(2, 32'h0000_2A00, 4'd0, 1);
        expect_burst(0, 32'h0000_0A00, 4'd0, 1);
`endif
        req(0, 32'h0000_0A00, 4'd0);
        req(2, 32'h0000_2A00, 4'd0);
        wait_idle("wd_rr", 60);

        // Contention from rr=0, port 0 re-requests immediately
        apply_reset();
        req(0, 32'h0000_1000, 4'd0);
        req(1, 32'h0000_2000, 4'd0);
        req(2, 32'h0000_3000, 4'd0);
        req(0, 32'h0000_1100, 4'd0);
`ifdef AXI3_RD_ARB_FIXED_PRIO_EN
        expect_burst(0, 32'h0000_1000, 4'd0, 1);
        expect_burst(0, 32'h0000_1100, 4'd0, 1);
        expect_burst(1, 32'h0000_2000, 4'd0, 1);
        expect_burst(2, 32'h0000_3000, 4'd0, 1);
`else
        expect_burst(0, 32'h0000_1000, 4'd0, 1);
        expect_burst(1, 32'h0000_2000, 4'd0, 1);
        expect_burst(2, 32'h0000_3000, 4'd0, 1);
        expect_burst(0, 32'h0000_1100, 4'd0, 1);
`endif
        wait_idle("cont", 80);

        // Backpressure: AR stalled 5 cycles in ADDR, then rready toggles
        base = hs_cnt[1];
        ar_stall = 6;
        rtoggle = 1'b1;
        req_exp(1, 32'h8000_0040, 4'd7, 8);
        step();
        step();
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_arvalid_held", 64'(m_arvalid), 64'd1);
            chk("bp_araddr_stable", 64'(m_araddr), 64'h8000_0040);
            chk("bp_arlen_stable", 64'(m_arlen), 64'd7);
        end
        wait_idle("bp", 80);
        rtoggle = 1'b0;
        chk("bp_handshakes", 64'(hs_cnt[1] - base), 64'd8);

        // Burst error: arlen=3 but RLAST on beat 2
        short_n = 2;
        req_exp(0, 32'h0000_0040, 4'd3, 2);
        wait_idle("berr", 40);
        short_n = 0;
        chk("berr_err_set", 64'(err_burst), 64'd1);
        chk("berr_idle", 64'(busy), 64'd0);
        step(); step(); step();
        chk("berr_err_sticky", 64'(err_burst), 64'd1);

        // Reset after beat 3 of 8
        base = hs_cnt[2];
        req_exp(2, 32'h0000_0500, 4'd7, 8);
        n = 0;
        while (hs_cnt[2] - base < 3 && n < 60) begin
            step();
            n++;
        end
        chk("rmid_reached_beat3", 64'(hs_cnt[2] - base), 64'd3);
        rst = 1'b1;
        slave_q.delete();
        exp_r.delete();
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        step();
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_m_rready", 64'(m_rready), 64'd0);
        chk("rmid_s_rvalid", 64'(s_rvalid), 64'd0);
        chk("rmid_err", 64'(err_burst), 64'd0);
        rst = 1'b0;
        req_exp(1, 32'h0000_0600, 4'd1, 2);
        wait_idle("rmid_after", 40);
        chk("rmid_after_err", 64'(err_burst), 64'd0);
        chk("end_r_drained", 64'(exp_r.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi3_rd_arbiter.md
Name: axi3_rd_arbiter

Overview:
- Shares the single AXI3 read channel between N read masters:
  - port 0: i$ stream-buffer refill
  - port 1: d$ refill
  - port 2: uncached load path
- One outstanding burst at a time. Grant is held from AR issue until the R beat carrying RLAST.
- Round-robin arbitration by default. Sits between the cache/uncached read engines and the top-level AXI3 master port.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 32, AR address width
- DATA_WIDTH, 32, R data width
- ID_WIDTH, 4, ARID/RID width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_arvalid  in  N_REQ  per-requester AR valid
- s_araddr  in  N_REQ*ADDR_WIDTH  per-requester address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_arlen  in  N_REQ*4  burst length-1
- s_arsize  in  N_REQ*3  beat size
- s_arburst  in  N_REQ*2  burst type
- s_arid  in  N_REQ*ID_WIDTH  transaction id
- s_arready  out  N_REQ  per-requester AR ready
- s_rvalid  out  N_REQ  per-requester R valid
- s_rdata  out  DATA_WIDTH  R data, broadcast to all requesters
- s_rresp  out  2  R response, broadcast
- s_rlast  out  1  R last, broadcast
- s_rid  out  ID_WIDTH  R id, broadcast
- s_rready  in  N_REQ  per-requester R ready
- m_arvalid/m_araddr/m_arlen/m_arsize/m_arburst/m_arid  out  1/ADDR_WIDTH/4/3/2/ID_WIDTH  master AR channel
- m_arready  in  1  master AR ready
- m_rvalid/m_rdata/m_rresp/m_rlast/m_rid  in  1/DATA_WIDTH/2/1/ID_WIDTH  master R channel
- m_rready  out  1  master R ready
- grant  out  $clog2(N_REQ)  index of current owner; valid when busy=1
- busy  out  1  arbiter in ADDR or DATA state
- err_burst  out  1  sticky burst-length mismatch flag

Behaviour:
- States: ARB_IDLE, ARB_ADDR, ARB_DATA.
- Reset:
  - State ARB_IDLE, grant=0, round-robin pointer rr=0, beat counter=0, err_burst=0.
  - All valid/ready outputs 0; busy=0.
  - Reset mid-burst abandons the burst: no further beats are forwarded and m_rready=0 after reset.
- ARB_IDLE:
  - All s_arready, s_rvalid, m_arvalid and m_rready are 0.
  - If |s_arvalid, register winner = first set bit at or after rr (wrapping modulo N_REQ) into grant; next state ARB_ADDR.
  - Arbitration latency: 1 cycle. Earliest m_arvalid is the cycle after s_arvalid is first sampled.
- ARB_ADDR:
  - m_ar* = slice[grant] of s_ar*, combinational.
  - m_arvalid = s_arvalid[grant]; s_arready[grant] = m_arready; other s_arready = 0.
  - On the m_arvalid & m_arready handshake: load beat counter = s_arlen[grant]; go to ARB_DATA.
  - If s_arvalid[grant] drops before the handshake (protocol violation): return to ARB_IDLE; rr unchanged.
- ARB_DATA:
  - s_rvalid[grant] = m_rvalid; other s_rvalid = 0; m_rready = s_rready[grant].
  - s_rdata/s_rresp/s_rlast/s_rid = m_r* passthrough, zero-latency.
  - Each R handshake decrements the beat counter (4-bit, no wrap below 0).
  - On a handshake with m_rlast=1: go to ARB_IDLE; rr = grant+1, wrapping to 0 at N_REQ.
  - err_burst is set and held until rst if either:
    - m_rlast=1 arrives while counter != 0, or
    - a handshake occurs with counter == 0 and m_rlast=0.
  - The state still exits only on m_rlast.
- New s_arvalid assertions during ADDR/DATA are ignored until IDLE; no back-to-back overlap. Minimum gap from last beat to the next AR is 1 cycle (the IDLE cycle).
- busy = (state != ARB_IDLE); grant is stable for the whole ADDR+DATA period.

Optional Feature:
- Macro: AXI3_RD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; lowest requester index wins in ARB_IDLE and rr is neither updated nor used, so i$ refill (port 0) always wins over d$.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Single req: port 1 asserts AR, addr 0x1FC00020, arlen=7; slave returns 8 beats -> m_araddr=0x1FC00020 on cycle 1 after request; s_rvalid[1] pulses 8 times; s_rvalid[0,2] stay 0; IDLE after beat 8; err_burst=0.
- Contention: ports 0,1,2 assert simultaneously, each arlen=0, rr=0 -> grant order 0,1,2. Port 0 re-asserts immediately -> order continues 0,1,2,0 (round-robin); with AXI3_RD_ARB_FIXED_PRIO_EN -> 0,0,… while port 0 keeps requesting.
- Backpressure: m_arready held 0 for 5 cycles, then s_rready[grant] toggles 1/0 during an 8-beat burst -> AR fields stable throughout; exactly 8 handshakes; no beat lost or duplicated.
- Burst error: arlen=3, slave asserts rlast on beat 2 -> err_burst=1 from next cycle; state returns to IDLE; err_burst stays 1 until rst.
- Reset mid-burst: rst asserted after beat 3 of 8 -> next cycle busy=0, m_rready=0, all s_rvalid=0, err_burst=0; a new request after reset is granted normally.
- Withdrawn AR: port 2 granted, drops s_arvalid before m_arready -> return to IDLE, no m_arvalid handshake, rr unchanged.
